// File: rtl/grid_stager_if.sv
// grid_stager_if: char stream in, grid memory write port out.
// master = stager side, slave = stream source / memory side.
interface grid_stager_if #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 3
);
  logic              char_valid_in;
  logic [7:0]        char_in;
  logic              char_last_in;
  logic              char_ready_out;
  logic              mem_ack_in;
  logic              mem_busy_in;
  logic              staging_out;
  logic              write_en_out;
  logic              read_en_out;
  logic [ROW_W-1:0]  row_addr_out;
  logic [COL_W-1:0]  col_addr_out;
  logic [DATA_W-1:0] partial_vec_out;

  modport master (
    input  char_valid_in, char_in, char_last_in,
    input  mem_ack_in, mem_busy_in,
    output char_ready_out, staging_out,
    output write_en_out, read_en_out,
    output row_addr_out, col_addr_out,
    output partial_vec_out
  );

  modport slave (
    output char_valid_in, char_in, char_last_in,
    output mem_ack_in, mem_busy_in,
    input  char_ready_out, staging_out,
    input  write_en_out, read_en_out,
    input  row_addr_out, col_addr_out,
    input  partial_vec_out
  );
endinterface

// File: rtl/grid_stager.sv
// grid_stager: packs a serial '@'/'.' grid stream into word writes
// to the grid memory, then hands the memory to the removal machines.
module grid_stager #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 3
) (
  input  logic           clock,
  input  logic           reset,
  grid_stager_if.master  bus,
  output logic           run_out,
  output logic [ROW_W:0] rows_out,
  output logic [15:0]    cols_out,
  output logic           done_out,
  output logic           err_out
);

  typedef enum logic [2:0] {
    ACCUM, ISSUE, WAIT_ACK, FINISH, DONE
  } state_t;

  localparam int IW = $clog2(DATA_W);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);

  state_t state, state_nx;

  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] vec;
  logic [ROW_W:0]    row;
  logic [COL_W:0]    col;
  logic [15:0]       row_chars;
  logic              pend_eor;
  logic              pend_last;
  logic              first_done;

  logic              acc;
  logic              is_nl;
  logic              is_at;
  logic              is_dot;
  logic              is_data;
  logic [CW-1:0]     cnt_nx;
  logic [15:0]       chars_nx;
  logic [DATA_W-1:0] vec_nx;
  logic              need_wr;
  logic              end_row;
  logic              ovf;
  logic              adv;
  logic              adv_eor;
  logic              row_end;
  logic [15:0]       row_len;

  // Top bits of row/col mark addresses past the end of memory.
  always_comb begin
    acc      = (state == ACCUM) && bus.char_valid_in;
    is_nl    = bus.char_in == 8'h0A;
    is_at    = bus.char_in == 8'h40;
    is_dot   = bus.char_in == 8'h2E;
    is_data  = !is_nl;
    cnt_nx   = bit_cnt + CW'(is_data);
    chars_nx = row_chars
             + 16'(is_data && (row_chars != 16'hFFFF));
    vec_nx   = vec;
    if (is_at) vec_nx[bit_cnt[IW-1:0]] = 1'b1;
    need_wr  = (cnt_nx == FULL)
             || ((is_nl || bus.char_last_in)
                 && (cnt_nx != '0));
    end_row  = (is_nl || bus.char_last_in)
             && (chars_nx != '0);
    ovf      = row[ROW_W] | col[COL_W];
    adv      = ((state == WAIT_ACK) && bus.mem_ack_in)
             || (acc && need_wr && ovf);
    adv_eor  = (state == ACCUM) ? end_row : pend_eor;
    row_end  = (adv && adv_eor)
             || (acc && !need_wr && end_row);
    row_len  = (state == ACCUM) ? chars_nx : row_chars;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ACCUM;
    else       state <= state_nx;
  end

  // An idle memory skips ISSUE so the write starts the next cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: begin
        if (acc) begin
          if (need_wr && !ovf)
            state_nx = bus.mem_busy_in ? ISSUE : WAIT_ACK;
          else if (bus.char_last_in)
            state_nx = FINISH;
        end
      end
      ISSUE: begin
        if (!bus.mem_busy_in) state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.mem_ack_in)
          state_nx = pend_last ? FINISH : ACCUM;
      end
      FINISH:  state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = ACCUM;
    endcase
  end

  always_comb begin
    bus.char_ready_out  = state == ACCUM;
    bus.write_en_out    = state == WAIT_ACK;
    bus.read_en_out     = 1'b0;
    bus.staging_out     = !((state == FINISH)
                         || (state == DONE));
    bus.row_addr_out    = row[ROW_W-1:0];
    bus.col_addr_out    = col[COL_W-1:0];
    bus.partial_vec_out = vec;
    run_out             = state == FINISH;
    done_out            = state == DONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt    <= '0;
      vec        <= '0;
      row        <= '0;
      col        <= '0;
      row_chars  <= '0;
      pend_eor   <= 1'b0;
      pend_last  <= 1'b0;
      first_done <= 1'b0;
      rows_out   <= '0;
      cols_out   <= '0;
      err_out    <= 1'b0;
    end else begin
      if (acc) begin
        row_chars <= chars_nx;
        bit_cnt   <= cnt_nx;
        vec       <= vec_nx;
        pend_eor  <= end_row;
        pend_last <= bus.char_last_in;
        if (is_data && !is_at && !is_dot)
          err_out <= 1'b1;
        if (need_wr && ovf)
          err_out <= 1'b1;
      end
      if (adv) begin
        bit_cnt <= '0;
        vec     <= '0;
        if (!adv_eor && !col[COL_W])
          col <= col + (COL_W+1)'(1);
      end
      // Row close: width check against the first row.
      if (row_end) begin
        col       <= '0;
        row_chars <= '0;
        if (!row[ROW_W]) begin
          row      <= row + (ROW_W+1)'(1);
          rows_out <= rows_out + (ROW_W+1)'(1);
        end
        if (!first_done) begin
          first_done <= 1'b1;
          cols_out   <= row_len;
        end else if (row_len != cols_out) begin
          err_out <= 1'b1;
        end
      end
    end
  end

endmodule
